useq_control: RTL and testbench

USEQ_CONTROL -- requirements
Module: useq_control

---
 rtl/useq_pkg.sv | 65 ++++++
 rtl/useq_nextaddr.sv | 44 ++++
 rtl/useq_control.sv | 181 ++++++++++++++++++
 tb/tb_useq_control.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/useq_pkg.sv
// Shared definitions for the microsequencer: COND encodings, FSM states, microword layout.
// The ERR state exists only when USEQ_CONTROL_ACK_TIMEOUT_EN is defined.
package useq_pkg;

    localparam int DEF_SELECTION_W = 6;
    localparam int DEF_ALU_W       = 4;
    localparam int DEF_DECODEOP_W  = 8;
    localparam int DEF_UADDR_W     = DEF_DECODEOP_W + 3;

    typedef enum logic [2:0] {
        COND_NEXT   = 3'd0,
        COND_NEG    = 3'd1,
        COND_ZERO   = 3'd2,
        COND_OVF    = 3'd3,
        COND_CARRY  = 3'd4,
        COND_IR13   = 3'd5,
        COND_JUMP   = 3'd6,
        COND_DECODE = 3'd7
    } cond_e;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2
`ifdef USEQ_CONTROL_ACK_TIMEOUT_EN
        , ST_ERR = 2'd3
`endif
    } state_e;

    // Field LSB offsets, MSB-first order: A DirA B DirB C DirC RD WR ALU COND JADDR
    function automatic int uword_width(int sel_w, int alu_w, int uaddr_w);
        return 3*sel_w + 3 + 2 + alu_w + 3 + uaddr_w;
    endfunction
    function automatic int off_cond(int uaddr_w);
        return uaddr_w;
    endfunction
    function automatic int off_alu(int uaddr_w);
        return uaddr_w + 3;
    endfunction
    function automatic int off_wr(int alu_w, int uaddr_w);
        return uaddr_w + 3 + alu_w;
    endfunction
    function automatic int off_rd(int alu_w, int uaddr_w);
        return off_wr(alu_w, uaddr_w) + 1;
    endfunction
    function automatic int off_dirc(int alu_w, int uaddr_w);
        return off_wr(alu_w, uaddr_w) + 2;
    endfunction
    function automatic int off_c(int alu_w, int uaddr_w);
        return off_wr(alu_w, uaddr_w) + 3;
    endfunction
    function automatic int off_dirb(int sel_w, int alu_w, int uaddr_w);
        return off_c(alu_w, uaddr_w) + sel_w;
    endfunction
    function automatic int off_b(int sel_w, int alu_w, int uaddr_w);
        return off_dirb(sel_w, alu_w, uaddr_w) + 1;
    endfunction
    function automatic int off_dira(int sel_w, int alu_w, int uaddr_w);
        return off_b(sel_w, alu_w, uaddr_w) + sel_w;
    endfunction
    function automatic int off_a(int sel_w, int alu_w, int uaddr_w);
        return off_dira(sel_w, alu_w, uaddr_w) + 1;
    endfunction

endpackage

// File: rtl/useq_nextaddr.sv
// Combinational next-microaddress mux: increment, conditional jump on PSR/IR13,
// unconditional jump, or opcode dispatch into the {1, opcode, 00} region.
module useq_nextaddr
    import useq_pkg::*;
#(
    parameter int DATAWIDTH_DECODEROP = DEF_DECODEOP_W,
    parameter int DATAWIDTH_UADDR     = DATAWIDTH_DECODEROP + 3
) (
    input  logic [DATAWIDTH_UADDR-1:0]     upc,
    input  logic [DATAWIDTH_UADDR-1:0]     jaddr,
    input  logic [2:0]                     cond,
    input  logic                           flag_n,
    input  logic                           flag_z,
    input  logic                           flag_v,
    input  logic                           flag_c,
    input  logic                           ir13,
    input  logic [DATAWIDTH_DECODEROP-1:0] decode_op,
    output logic [DATAWIDTH_UADDR-1:0]     next_addr
);

    logic take;

    always_comb begin
        take = 1'b0;
        case (cond_e'(cond))
            COND_NEXT:   take = 1'b0;
            COND_NEG:    take = flag_n;
            COND_ZERO:   take = flag_z;
            COND_OVF:    take = flag_v;
            COND_CARRY:  take = flag_c;
            COND_IR13:   take = ir13;
            COND_JUMP:   take = 1'b1;
            COND_DECODE: take = 1'b0;
        endcase

        // Increment wraps naturally at the address width
        next_addr = upc + DATAWIDTH_UADDR'(1);
        if (cond_e'(cond) == COND_DECODE)
            next_addr = DATAWIDTH_UADDR'({1'b1, decode_op, 2'b00});
        else if (take)
            next_addr = jaddr;
    end

endmodule

// File: rtl/useq_control.sv
// Microsequencer control: MIR/uPC/PSR registers and BOOT/RUN/WAIT FSM with memory handshake.
// Define USEQ_CONTROL_ACK_TIMEOUT_EN to add the ACK timeout counter and the sticky ERR state.
module useq_control
    import useq_pkg::*;
#(
    parameter int DATAWIDTH_SELECTION     = DEF_SELECTION_W,
    parameter int DATAWIDTH_ALU_SELECTION = DEF_ALU_W,
    parameter int DATAWIDTH_DECODEROP     = DEF_DECODEOP_W,
    parameter int DATAWIDTH_UADDR         = DATAWIDTH_DECODEROP + 3,
    parameter int TIMEOUT_CYCLES          = 255
) (
    input  logic                               USEQ_CONTROL_CLOCK_50,
    input  logic                               USEQ_CONTROL_ResetInLow_In,
    input  logic                               USEQ_CONTROL_ACK_In,
    input  logic [DATAWIDTH_DECODEROP-1:0]     USEQ_CONTROL_DecodeOP_InBus,
    input  logic                               USEQ_CONTROL_IR13_In,
    input  logic                               USEQ_CONTROL_FlagOverflow_In,
    input  logic                               USEQ_CONTROL_FlagNegative_In,
    input  logic                               USEQ_CONTROL_FlagCarry_In,
    input  logic                               USEQ_CONTROL_FlagZero_In,
    input  logic                               USEQ_CONTROL_SetCodes_In,
    input  logic [3*DATAWIDTH_SELECTION+3+2+DATAWIDTH_ALU_SELECTION+3+DATAWIDTH_UADDR-1:0]
                                               USEQ_CONTROL_uWord_InBus,
    output logic [DATAWIDTH_UADDR-1:0]         USEQ_CONTROL_uAddr_OutBus,
    output logic [DATAWIDTH_SELECTION-1:0]     USEQ_CONTROL_SelectA_OutBus,
    output logic [DATAWIDTH_SELECTION-1:0]     USEQ_CONTROL_SelectB_OutBus,
    output logic [DATAWIDTH_SELECTION-1:0]     USEQ_CONTROL_SelectC_OutBus,
    output logic                               USEQ_CONTROL_DirA_Out,
    output logic                               USEQ_CONTROL_DirB_Out,
    output logic                               USEQ_CONTROL_DirC_Out,
    output logic                               USEQ_CONTROL_RD_Out,
    output logic                               USEQ_CONTROL_WRMain_Out,
    output logic [DATAWIDTH_ALU_SELECTION-1:0] USEQ_CONTROL_ALUOperation_OutBus,
    output logic                               USEQ_CONTROL_Stall_Out,
    output logic                               USEQ_CONTROL_Error_Out
);

    localparam int SEL_W   = DATAWIDTH_SELECTION;
    localparam int ALU_W   = DATAWIDTH_ALU_SELECTION;
    localparam int UADDR_W = DATAWIDTH_UADDR;
    localparam int UWORD_W = uword_width(SEL_W, ALU_W, UADDR_W);

    localparam int OFF_COND = off_cond(UADDR_W);
    localparam int OFF_ALU  = off_alu(UADDR_W);
    localparam int OFF_WR   = off_wr(ALU_W, UADDR_W);
    localparam int OFF_RD   = off_rd(ALU_W, UADDR_W);
    localparam int OFF_DIRC = off_dirc(ALU_W, UADDR_W);
    localparam int OFF_C    = off_c(ALU_W, UADDR_W);
    localparam int OFF_DIRB = off_dirb(SEL_W, ALU_W, UADDR_W);
    localparam int OFF_B    = off_b(SEL_W, ALU_W, UADDR_W);
    localparam int OFF_DIRA = off_dira(SEL_W, ALU_W, UADDR_W);
    localparam int OFF_A    = off_a(SEL_W, ALU_W, UADDR_W);

    state_e               state;
    state_e               state_next;
    logic [UWORD_W-1:0]   mir;
    logic [UADDR_W-1:0]   upc;
    logic [UADDR_W-1:0]   next_addr;
    logic [UADDR_W-1:0]   uaddr;
    logic                 psr_n, psr_z, psr_v, psr_c;
    logic                 mem_req;
    logic                 advance;

    assign mem_req = mir[OFF_RD] | mir[OFF_WR];

    useq_nextaddr #(
        .DATAWIDTH_DECODEROP (DATAWIDTH_DECODEROP),
        .DATAWIDTH_UADDR     (UADDR_W)
    ) u_nextaddr (
        .upc       (upc),
        .jaddr     (mir[UADDR_W-1:0]),
        .cond      (mir[OFF_COND +: 3]),
        .flag_n    (psr_n),
        .flag_z    (psr_z),
        .flag_v    (psr_v),
        .flag_c    (psr_c),
        .ir13      (USEQ_CONTROL_IR13_In),
        .decode_op (USEQ_CONTROL_DecodeOP_InBus),
        .next_addr (next_addr)
    );

`ifdef USEQ_CONTROL_ACK_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] wait_cnt;

    // Counts consecutive un-acknowledged WAIT cycles
    always_ff @(posedge USEQ_CONTROL_CLOCK_50 or negedge USEQ_CONTROL_ResetInLow_In) begin
        if (!USEQ_CONTROL_ResetInLow_In)
            wait_cnt <= '0;
        else if (state == ST_WAIT && !USEQ_CONTROL_ACK_In)
            wait_cnt <= wait_cnt + TO_W'(1);
        else
            wait_cnt <= '0;
    end
`endif

    always_ff @(posedge USEQ_CONTROL_CLOCK_50 or negedge USEQ_CONTROL_ResetInLow_In) begin
        if (!USEQ_CONTROL_ResetInLow_In)
            state <= ST_BOOT;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_BOOT: state_next = ST_RUN;
            ST_RUN:  if (mem_req && !USEQ_CONTROL_ACK_In) state_next = ST_WAIT;
            ST_WAIT: begin
                if (USEQ_CONTROL_ACK_In)
                    state_next = ST_RUN;
`ifdef USEQ_CONTROL_ACK_TIMEOUT_EN
                else if (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1))
                    state_next = ST_ERR;
`endif
            end
`ifdef USEQ_CONTROL_ACK_TIMEOUT_EN
            ST_ERR:  state_next = ST_ERR;
`endif
            default: state_next = ST_BOOT;
        endcase
    end

    always_comb begin
        uaddr                            = next_addr;
        advance                          = 1'b0;
        USEQ_CONTROL_Stall_Out           = 1'b0;
        USEQ_CONTROL_Error_Out           = 1'b0;
        USEQ_CONTROL_RD_Out              = mir[OFF_RD];
        USEQ_CONTROL_WRMain_Out          = mir[OFF_WR];
        USEQ_CONTROL_ALUOperation_OutBus = mir[OFF_ALU +: ALU_W];
        case (state)
            ST_BOOT: begin
                uaddr   = '0;
                advance = 1'b1;
            end
            ST_RUN:  advance = !mem_req || USEQ_CONTROL_ACK_In;
            ST_WAIT: begin
                USEQ_CONTROL_Stall_Out = 1'b1;
                advance                = USEQ_CONTROL_ACK_In;
            end
`ifdef USEQ_CONTROL_ACK_TIMEOUT_EN
            ST_ERR: begin
                USEQ_CONTROL_Error_Out           = 1'b1;
                USEQ_CONTROL_RD_Out              = 1'b0;
                USEQ_CONTROL_WRMain_Out          = 1'b0;
                USEQ_CONTROL_ALUOperation_OutBus = '0;
            end
`endif
            default: ;
        endcase
    end

    // BOOT drives uaddr=0, so loading uPC from uaddr also covers the boot case
    always_ff @(posedge USEQ_CONTROL_CLOCK_50 or negedge USEQ_CONTROL_ResetInLow_In) begin
        if (!USEQ_CONTROL_ResetInLow_In) begin
            mir <= '0;
            upc <= '0;
        end else if (advance) begin
            mir <= USEQ_CONTROL_uWord_InBus;
            upc <= uaddr;
        end
    end

    always_ff @(posedge USEQ_CONTROL_CLOCK_50 or negedge USEQ_CONTROL_ResetInLow_In) begin
        if (!USEQ_CONTROL_ResetInLow_In)
            {psr_n, psr_z, psr_v, psr_c} <= '0;
        else if (USEQ_CONTROL_SetCodes_In)
            {psr_n, psr_z, psr_v, psr_c} <= {USEQ_CONTROL_FlagNegative_In, USEQ_CONTROL_FlagZero_In,
                                             USEQ_CONTROL_FlagOverflow_In, USEQ_CONTROL_FlagCarry_In};
    end

    assign USEQ_CONTROL_uAddr_OutBus   = uaddr;
    assign USEQ_CONTROL_SelectA_OutBus = mir[OFF_A +: SEL_W];
    assign USEQ_CONTROL_SelectB_OutBus = mir[OFF_B +: SEL_W];
    assign USEQ_CONTROL_SelectC_OutBus = mir[OFF_C +: SEL_W];
    assign USEQ_CONTROL_DirA_Out       = mir[OFF_DIRA];
    assign USEQ_CONTROL_DirB_Out       = mir[OFF_DIRB];
    assign USEQ_CONTROL_DirC_Out       = mir[OFF_DIRC];

endmodule

// File: tb/tb_useq_control.sv
// Testbench for useq_control: next-address vector table plus handshake, reset and timeout sequences.
// Covers the USEQ_CONTROL_ACK_TIMEOUT_EN build when that macro is defined.
module tb_useq_control;

    localparam int SEL_W   = 6;
    localparam int ALU_W   = 4;
    localparam int DEC_W   = 8;
    localparam int UADDR_W = 11;
    localparam int UW_W    = 3*SEL_W + 3 + 2 + ALU_W + 3 + UADDR_W;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               ack = 1'b0;
    logic [DEC_W-1:0]   dec = '0;
    logic               ir13 = 1'b0;
    logic               f_v = 1'b0, f_n = 1'b0, f_c = 1'b0, f_z = 1'b0;
    logic               setc = 1'b0;
    logic [UW_W-1:0]    uword = '0;

    logic [UADDR_W-1:0] uaddr;
    logic [SEL_W-1:0]   sel_a, sel_b, sel_c;
    logic               dir_a, dir_b, dir_c;
    logic               rd, wr, stall, err;
    logic [ALU_W-1:0]   alu;

    useq_control #(
        .DATAWIDTH_SELECTION     (SEL_W),
        .DATAWIDTH_ALU_SELECTION (ALU_W),
        .DATAWIDTH_DECODEROP     (DEC_W),
        .DATAWIDTH_UADDR         (UADDR_W),
        .TIMEOUT_CYCLES          (4)
    ) dut (
        .USEQ_CONTROL_CLOCK_50            (clk),
        .USEQ_CONTROL_ResetInLow_In       (rst_n),
        .USEQ_CONTROL_ACK_In              (ack),
        .USEQ_CONTROL_DecodeOP_InBus      (dec),
        .USEQ_CONTROL_IR13_In             (ir13),
        .USEQ_CONTROL_FlagOverflow_In     (f_v),
        .USEQ_CONTROL_FlagNegative_In     (f_n),
        .USEQ_CONTROL_FlagCarry_In        (f_c),
        .USEQ_CONTROL_FlagZero_In         (f_z),
        .USEQ_CONTROL_SetCodes_In         (setc),
        .USEQ_CONTROL_uWord_InBus         (uword),
        .USEQ_CONTROL_uAddr_OutBus        (uaddr),
        .USEQ_CONTROL_SelectA_OutBus      (sel_a),
        .USEQ_CONTROL_SelectB_OutBus      (sel_b),
        .USEQ_CONTROL_SelectC_OutBus      (sel_c),
        .USEQ_CONTROL_DirA_Out            (dir_a),
        .USEQ_CONTROL_DirB_Out            (dir_b),
        .USEQ_CONTROL_DirC_Out            (dir_c),
        .USEQ_CONTROL_RD_Out              (rd),
        .USEQ_CONTROL_WRMain_Out          (wr),
        .USEQ_CONTROL_ALUOperation_OutBus (alu),
        .USEQ_CONTROL_Stall_Out           (stall),
        .USEQ_CONTROL_Error_Out           (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string              name;
        bit                 chk_ua;
        logic [UADDR_W-1:0] ua;
        logic               stall;
        logic               rd;
        logic               wr;
        logic               err;
    } exp_t;

    // kind: 0 = uPC+1, 1 = JADDR, 2 = opcode dispatch
    typedef struct {
        logic [3:0]         nzvc;
        logic [2:0]         cond;
        logic [UADDR_W-1:0] jaddr;
        logic               ir13;
        logic [DEC_W-1:0]   dec;
        int                 kind;
    } vec_t;

    exp_t               sb[$];
    vec_t               vt[14];
    int                 n_pass = 0;
    int                 n_total = 0;
    logic [UADDR_W-1:0] exp_upc;
    logic [UADDR_W-1:0] exp_ua;
    logic [UADDR_W-1:0] held;

    function automatic logic [UW_W-1:0] mk(logic [5:0] a, logic da, logic [5:0] b, logic db,
                                           logic [5:0] c, logic dc, logic r, logic w,
                                           logic [3:0] op, logic [2:0] cond, logic [10:0] ja);
        return {a, da, b, db, c, dc, r, w, op, cond, ja};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    endtask

    task automatic push_exp(input string name, input bit cu, input logic [UADDR_W-1:0] ua,
                            input logic s, input logic r, input logic w, input logic e);
        exp_t x;
        x.name = name; x.chk_ua = cu; x.ua = ua; x.stall = s; x.rd = r; x.wr = w; x.err = e;
        sb.push_back(x);
    endtask

    task automatic sample();
        exp_t x;
        #1;
        x = sb.pop_front();
        if (x.chk_ua) chk({x.name, ".uaddr"}, 32'(uaddr), 32'(x.ua));
        chk({x.name, ".stall"}, 32'(stall), 32'(x.stall));
        chk({x.name, ".rd"},    32'(rd),    32'(x.rd));
        chk({x.name, ".wr"},    32'(wr),    32'(x.wr));
        chk({x.name, ".error"}, 32'(err),   32'(x.err));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One RUN cycle with a plain (no memory access) word already in MIR
    task automatic run_inc(input string name);
        exp_ua = exp_upc + 11'd1;
        push_exp(name, 1'b1, exp_ua, 1'b0, 1'b0, 1'b0, 1'b0);
        sample();
        exp_upc = exp_ua;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{4'b0100, 3'd2, 11'h100, 1'b0, 8'h00, 1};
        vt[1]  = '{4'b0000, 3'd2, 11'h100, 1'b0, 8'h00, 0};
        vt[2]  = '{4'b1000, 3'd1, 11'h055, 1'b0, 8'h00, 1};
        vt[3]  = '{4'b0010, 3'd1, 11'h055, 1'b0, 8'h00, 0};
        vt[4]  = '{4'b0010, 3'd3, 11'h3A0, 1'b0, 8'h00, 1};
        vt[5]  = '{4'b0001, 3'd4, 11'h7FF, 1'b0, 8'h00, 1};
        vt[6]  = '{4'b1110, 3'd4, 11'h0F0, 1'b0, 8'h00, 0};
        vt[7]  = '{4'b0000, 3'd5, 11'h222, 1'b1, 8'h00, 1};
        vt[8]  = '{4'b1111, 3'd5, 11'h222, 1'b0, 8'h00, 0};
        vt[9]  = '{4'b0000, 3'd6, 11'h600, 1'b0, 8'h00, 1};
        vt[10] = '{4'b1111, 3'd0, 11'h123, 1'b1, 8'h00, 0};
        vt[11] = '{4'b0000, 3'd7, 11'h000, 1'b0, 8'h25, 2};
        vt[12] = '{4'b0000, 3'd7, 11'h3C3, 1'b1, 8'hFF, 2};
        vt[13] = '{4'b1111, 3'd3, 11'h7FF, 1'b0, 8'h00, 1};

        // Reset held: MIR must read as zero even with a non-zero microword on the bus
        uword = '1;
        next_cycle();
        next_cycle();
        push_exp("reset", 1'b1, 11'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        sample();
        chk("reset.sel_a", 32'(sel_a), 32'h0);
        chk("reset.alu",   32'(alu),   32'h0);

        // Release with zero microwords: 0,1,2,3
        next_cycle();
        uword = '0;
        rst_n = 1'b1;
        push_exp("boot", 1'b1, 11'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        sample();
        exp_upc = 11'h000;
        for (int i = 1; i <= 3; i++) begin
            next_cycle();
            run_inc($sformatf("seq%0d", i));
        end

        // Next-address table: cycle A loads flags + word, cycle B checks the branch
        for (int i = 0; i < 14; i++) begin
            next_cycle();
            setc = 1'b1;
            {f_n, f_z, f_v, f_c} = vt[i].nzvc;
            uword = mk(6'h0, 1'b0, 6'h0, 1'b0, 6'h0, 1'b0, 1'b0, 1'b0, 4'h0, vt[i].cond, vt[i].jaddr);
            run_inc($sformatf("vec%0d_a", i));

            next_cycle();
            setc = 1'b0;
            {f_n, f_z, f_v, f_c} = 4'b0000;
            uword = '0;
            ir13 = vt[i].ir13;
            dec = vt[i].dec;
            case (vt[i].kind)
                1:       exp_ua = vt[i].jaddr;
                2:       exp_ua = {1'b1, vt[i].dec, 2'b00};
                default: exp_ua = exp_upc + 11'd1;
            endcase
            push_exp($sformatf("vec%0d_b", i), 1'b1, exp_ua, 1'b0, 1'b0, 1'b0, 1'b0);
            sample();
            exp_upc = exp_ua;
        end
        ir13 = 1'b0;
        dec = '0;
        // 0x7FF + 1 wraps to 0
        next_cycle();
        run_inc("wrap");

        // Datapath fields come straight from MIR
        next_cycle();
        uword = mk(6'h2A, 1'b1, 6'h15, 1'b0, 6'h3F, 1'b1, 1'b0, 1'b0, 4'hA, 3'd0, 11'h000);
        run_inc("fields_load");
        next_cycle();
        uword = '0;
        run_inc("fields");
        chk("fields.sel_a", 32'(sel_a), 32'h2A);
        chk("fields.sel_b", 32'(sel_b), 32'h15);
        chk("fields.sel_c", 32'(sel_c), 32'h3F);
        chk("fields.dirs",  32'({dir_a, dir_b, dir_c}), 32'b101);
        chk("fields.alu",   32'(alu),   32'hA);

        // Read with ACK late: stall holds uPC and RD until ACK
        next_cycle();
        uword = mk(6'h0, 1'b0, 6'h0, 1'b0, 6'h0, 1'b0, 1'b1, 1'b0, 4'h0, 3'd0, 11'h000);
        run_inc("rd_load");
        next_cycle();
        uword = mk(6'h0, 1'b0, 6'h0, 1'b0, 6'h0, 1'b0, 1'b0, 1'b0, 4'h0, 3'd6, 11'h0AB);
        held = exp_upc + 11'd1;
        push_exp("rd_run", 1'b1, held, 1'b0, 1'b1, 1'b0, 1'b0);
        sample();
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            push_exp($sformatf("rd_wait%0d", k), 1'b1, held, 1'b1, 1'b1, 1'b0, 1'b0);
            sample();
        end
        next_cycle();
        ack = 1'b1;
        push_exp("rd_ack", 1'b1, held, 1'b1, 1'b1, 1'b0, 1'b0);
        sample();
        exp_upc = held;
        next_cycle();
        ack = 1'b0;
        uword = '0;
        push_exp("rd_after", 1'b1, 11'h0AB, 1'b0, 1'b0, 1'b0, 1'b0);
        sample();
        exp_upc = 11'h0AB;

        // Read-modify-write acknowledged in the same cycle: no stall
        next_cycle();
        uword = mk(6'h0, 1'b0, 6'h0, 1'b0, 6'h0, 1'b0, 1'b1, 1'b1, 4'h5, 3'd0, 11'h000);
        run_inc("rmw_load");
        next_cycle();
        uword = '0;
        ack = 1'b1;
        exp_ua = exp_upc + 11'd1;
        push_exp("rmw_run", 1'b1, exp_ua, 1'b0, 1'b1, 1'b1, 1'b0);
        sample();
        exp_upc = exp_ua;
        next_cycle();
        ack = 1'b0;
        run_inc("rmw_after");

        // Reset in the middle of a WAIT cycle acts asynchronously
        next_cycle();
        uword = mk(6'h0, 1'b0, 6'h0, 1'b0, 6'h0, 1'b0, 1'b1, 1'b0, 4'h0, 3'd0, 11'h000);
        run_inc("rst_load");
        next_cycle();
        uword = '0;
        held = exp_upc + 11'd1;
        push_exp("rst_run", 1'b1, held, 1'b0, 1'b1, 1'b0, 1'b0);
        sample();
        next_cycle();
        push_exp("rst_wait", 1'b1, held, 1'b1, 1'b1, 1'b0, 1'b0);
        sample();
        #1;
        rst_n = 1'b0;
        push_exp("rst_async", 1'b1, 11'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        sample();
        next_cycle();
        rst_n = 1'b1;
        push_exp("rst_boot", 1'b1, 11'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        sample();
        exp_upc = 11'h000;
        next_cycle();
        run_inc("rst_first");

        // ACK never arrives
        next_cycle();
        uword = mk(6'h0, 1'b0, 6'h0, 1'b0, 6'h0, 1'b0, 1'b1, 1'b0, 4'h7, 3'd0, 11'h000);
        run_inc("to_load");
        next_cycle();
        uword = '0;
        held = exp_upc + 11'd1;
        push_exp("to_run", 1'b1, held, 1'b0, 1'b1, 1'b0, 1'b0);
        sample();
`ifdef USEQ_CONTROL_ACK_TIMEOUT_EN
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            push_exp($sformatf("to_wait%0d", k), 1'b1, held, 1'b1, 1'b1, 1'b0, 1'b0);
            sample();
        end
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            ack = (k == 2);
            push_exp($sformatf("to_err%0d", k), 1'b0, held, 1'b0, 1'b0, 1'b0, 1'b1);
            sample();
            chk($sformatf("to_err%0d.alu", k), 32'(alu), 32'h0);
        end
        next_cycle();
        ack = 1'b0;
        rst_n = 1'b0;
        push_exp("to_reset", 1'b1, 11'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        sample();
        next_cycle();
        rst_n = 1'b1;
        push_exp("to_boot", 1'b1, 11'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        sample();
        exp_upc = 11'h000;
        next_cycle();
        run_inc("to_resume");
`else
        for (int k = 0; k < 6; k++) begin
            next_cycle();
            push_exp($sformatf("to_wait%0d", k), 1'b1, held, 1'b1, 1'b1, 1'b0, 1'b0);
            sample();
            chk($sformatf("to_wait%0d.alu", k), 32'(alu), 32'h7);
        end
        next_cycle();
        ack = 1'b1;
        push_exp("to_ack", 1'b1, held, 1'b1, 1'b1, 1'b0, 1'b0);
        sample();
        exp_upc = held;
        next_cycle();
        ack = 1'b0;
        run_inc("to_resume");
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
